// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter: FSM state encodings and funct3 size codes.
// Latency: n/a (package).
// Backpressure: n/a (package).
// Contents: ARB_CORE/ARB_EXT state codes, load/store funct3 codes, counter width helper.
package data_mem_arbiter_pkg;

  // Arbiter FSM states
  localparam logic [0:0] ARB_CORE = 1'b0;  // core priority with starvation guard
  localparam logic [0:0] ARB_EXT  = 1'b1;  // locked external burst

  // funct3 size/sign codes carried on *_ubhw
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Bits needed to hold 0..max; never less than one bit so max=0 still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_sat_counter.sv
// Saturating up-counter with clear; clear and increment in the same cycle restart the count at 1.
// Latency: count updates at the clock edge following clr/inc.
// Backpressure: none; holds at MAX while inc stays high.
// Ports: clk, rst (sync, active-high), clr, inc in; cnt out [W-1:0].
module arb_sat_counter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear is applied before the increment so a clr+inc cycle starts a fresh run at 1.
  logic [W-1:0] base;
  assign base = clr ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (base < W'(MAX))) begin
      cnt <= base + W'(1);
    end else begin
      cnt <= base;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares RAM_B between the core MEM stage and an external requester, one access per cycle.
// Latency: grant, RAM mux and core_rdata are combinational; ext_rdata/ext_rvalid one cycle after a granted read.
// Backpressure: a denied core_req raises core_stall; a denied ext_req simply sees no ext_gnt and must hold.
// Ports: core_* (MEM-stage request, core_rdata, core_stall), ext_* (request, lock, ext_gnt, registered
//        ext_rvalid/ext_rdata), ram_* (RAM_B port A: addr/din/we/ubhw out, dout in), clk, rst (sync, active-high).
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned BURST_MAX  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_ubhw,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        ext_req,
  input  logic        ext_lock,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  input  logic [2:0]  ext_ubhw,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  output logic [2:0]  ram_ubhw,
  input  logic [31:0] ram_dout
);

  localparam int unsigned SW = cnt_width(STARVE_MAX);
  localparam int unsigned BW = cnt_width(BURST_MAX);

  logic [0:0]    state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;
  logic          core_gnt;
  logic          core_slot;
  logic          starved;
  logic          lock_cont;
  logic [BW:0]   burst_nv;

  // burst_cnt only reaches BURST_MAX in ARB_CORE right after a maxed-out burst: that cycle is the core's owed slot.
  assign core_slot = (state == ARB_CORE) && (burst_cnt == BW'(BURST_MAX));
  assign starved   = (starve_cnt == SW'(STARVE_MAX));

  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (state == ARB_EXT) begin
      ext_gnt  = ext_req;
      core_gnt = core_req && !ext_req;
    end else if (core_slot) begin
      core_gnt = core_req;
      ext_gnt  = ext_req && !core_req;
    end else if (core_req && ext_req) begin
      ext_gnt  = starved;
      core_gnt = !starved;
    end else begin
      core_gnt = core_req;
      ext_gnt  = ext_req;
    end
  end

  assign core_stall = core_req && !core_gnt;

  // Burst bookkeeping: burst_nv is the number of locked grants including this one.
  assign lock_cont = ext_gnt && ext_lock;
  assign burst_nv  = (state == ARB_EXT) ? ({1'b0, burst_cnt} + (BW + 1)'(1)) : (BW + 1)'(1);
  assign state_nxt = (lock_cont && (burst_nv < (BW + 1)'(BURST_MAX))) ? ARB_EXT : ARB_CORE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_CORE;
    end else begin
      state <= state_nxt;
    end
  end

  // Consecutive cycles ext_req has lost; any ext grant or idle ext side resets the run.
  arb_sat_counter #(.MAX(STARVE_MAX), .W(SW)) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .clr (ext_gnt || !ext_req),
    .inc (ext_req && !ext_gnt),
    .cnt (starve_cnt)
  );

  // Locked grants in the current burst; ARB_CORE always restarts it (at 1 when a lock grant opens a burst).
  arb_sat_counter #(.MAX(BURST_MAX), .W(BW)) u_burst_cnt (
    .clk (clk),
    .rst (rst),
    .clr ((state == ARB_CORE) || !lock_cont),
    .inc (lock_cont),
    .cnt (burst_cnt)
  );

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    ram_ubhw = '0;
    if (core_gnt) begin
      ram_we   = core_we;
      ram_addr = core_addr;
      ram_din  = core_wdata;
      ram_ubhw = core_ubhw;
    end else if (ext_gnt) begin
      ram_we   = ext_we;
      ram_addr = ext_addr;
      ram_din  = ext_wdata;
      ram_ubhw = ext_ubhw;
    end
  end

  assign core_rdata = core_gnt ? ram_dout : '0;

  // RAM_B reads asynchronously, so the ext response is captured at the edge closing the grant cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      ext_rvalid <= ext_gnt && !ext_we;
      if (ext_gnt && !ext_we) begin
        ext_rdata <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a word-wide RAM_B stand-in and an arbitration reference model.
// Latency: n/a (testbench).
// Backpressure: requesters hold request and fields while denied.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int BURST_MAX  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [2:0]  core_ubhw;
  logic        core_stall;
  logic        ext_req, ext_lock, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic [2:0]  ext_ubhw;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ram_addr, ram_din, ram_dout;
  logic        ram_we;
  logic [2:0]  ram_ubhw;

  always #5 clk = ~clk;

  data_mem_arbiter #(.STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ubhw(core_ubhw), .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_lock(ext_lock), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ubhw(ext_ubhw), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_ubhw(ram_ubhw), .ram_dout(ram_dout)
  );

  // RAM_B stand-in: 256 words, async read, write at the clock edge.
  logic [31:0] ram [256];
  logic        ram_clr;
  assign ram_dout = ram[ram_addr[9:2]];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (ram_we) begin
      ram[ram_addr[9:2]] <= ram_din;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: plain counts of losses and burst length, plus a shadow of memory.
  logic [31:0] shadow [256];
  int          losses = 0;
  int          bgrants = 0;
  bit          in_burst = 0;
  bit          core_owed = 0;
  bit          exp_rvalid = 0;
  logic [31:0] exp_rdata = '0;

  // Observations from the last step, for directed checks and driver decisions.
  bit          obs_ext_gnt, obs_core_gnt, obs_stall, obs_rvalid;
  logic [31:0] obs_core_rdata, obs_rdata;

  task automatic step();
    bit          gc, ge;
    logic        e_we;
    logic [31:0] e_addr, e_din;
    logic [2:0]  e_ub;
    #3;
    gc = 0; ge = 0;
    if (in_burst) begin
      ge = ext_req; gc = core_req && !ext_req;
    end else if (core_owed) begin
      gc = core_req; ge = ext_req && !core_req;
    end else if (core_req && ext_req) begin
      ge = (losses >= STARVE_MAX); gc = !ge;
    end else begin
      gc = core_req; ge = ext_req;
    end
    e_we   = gc ? core_we    : (ge ? ext_we    : 1'b0);
    e_addr = gc ? core_addr  : (ge ? ext_addr  : 32'h0);
    e_din  = gc ? core_wdata : (ge ? ext_wdata : 32'h0);
    e_ub   = gc ? core_ubhw  : (ge ? ext_ubhw  : 3'h0);
    check_val("ext_gnt",    32'(ext_gnt),    32'(ge));
    check_val("core_stall", 32'(core_stall), 32'(core_req && !gc));
    check_val("ram_we",     32'(ram_we),     32'(e_we));
    check_val("ram_addr",   ram_addr,        e_addr);
    check_val("ram_din",    ram_din,         e_din);
    check_val("ram_ubhw",   32'(ram_ubhw),   32'(e_ub));
    check_val("core_rdata", core_rdata,      gc ? shadow[core_addr[9:2]] : 32'h0);
    obs_ext_gnt    = ext_gnt;
    obs_stall      = core_stall;
    obs_core_gnt   = core_req && !core_stall;
    obs_core_rdata = core_rdata;
    @(posedge clk);
    if (ge && !ext_we) exp_rdata = shadow[ext_addr[9:2]];
    exp_rvalid = ge && !ext_we;
    if (gc && core_we) shadow[core_addr[9:2]] = core_wdata;
    if (ge && ext_we)  shadow[ext_addr[9:2]]  = ext_wdata;
    if (rst) begin
      losses = 0; bgrants = 0; in_burst = 0; core_owed = 0;
      exp_rvalid = 0; exp_rdata = '0;
    end else begin
      losses = (ge || !ext_req) ? 0 : ((losses < STARVE_MAX) ? losses + 1 : STARVE_MAX);
      if (ge && ext_lock) begin
        bgrants   = in_burst ? bgrants + 1 : 1;
        in_burst  = (bgrants < BURST_MAX);
        core_owed = (bgrants >= BURST_MAX);
      end else begin
        bgrants = 0; in_burst = 0; core_owed = 0;
      end
    end
    #1;
    check_val("ext_rvalid", 32'(ext_rvalid), 32'(exp_rvalid));
    check_val("ext_rdata",  ext_rdata,       exp_rdata);
    obs_rvalid = ext_rvalid;
    obs_rdata  = ext_rdata;
  endtask

  task automatic core_set(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] ub);
    core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d; core_ubhw = ub;
  endtask

  task automatic core_idle();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_ubhw = '0;
  endtask

  task automatic ext_set(input logic lock, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] ub);
    ext_req = 1'b1; ext_lock = lock; ext_we = we; ext_addr = a; ext_wdata = d; ext_ubhw = ub;
  endtask

  task automatic ext_idle();
    ext_req = 1'b0; ext_lock = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; ext_ubhw = '0;
  endtask

  initial begin
    logic [31:0] epat, cpat;
    logic [5:0]  gpat, spat;
    int          k, cyc, nbad;
    bit          core_done;

    for (int i = 0; i < 256; i++) shadow[i] = '0;
    core_idle(); ext_idle();
    rst = 1'b1; ram_clr = 1'b1;
    step(); step();
    rst = 1'b0; ram_clr = 1'b0;

    // 1: idle after reset, every output at zero
    step();
    check_val("t1_ext_gnt", 32'(obs_ext_gnt), 32'h0);
    check_val("t1_rvalid",  32'(obs_rvalid),  32'h0);

    // 2: core store then load
    core_set(1'b1, 32'h40, 32'hDEADBEEF, F3_SW); step();
    check_val("t2_store_stall", 32'(obs_stall), 32'h0);
    core_set(1'b0, 32'h40, 32'h0, F3_LW); step();
    check_val("t2_load_stall", 32'(obs_stall), 32'h0);
    check_val("t2_load_data",  obs_core_rdata, 32'hDEADBEEF);
    core_idle(); step();

    // 3: both held, core wins STARVE_MAX cycles then ext is forced once
    core_set(1'b0, 32'h10, 32'h0, F3_LW);
    ext_set(1'b0, 1'b0, 32'h20, 32'h0, F3_LW);
    gpat = '0; spat = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      gpat[i] = obs_ext_gnt;
      spat[i] = obs_stall;
    end
    check_val("t3_ext_gnt_pattern", 32'(gpat), 32'h10);
    check_val("t3_stall_pattern",   32'(spat), 32'h10);
    core_idle(); ext_idle(); step();

    // 4: locked burst of 12 writes against a core load
    k = 0; cyc = 0; core_done = 0; epat = '0; cpat = '0;
    ext_set(1'b1, 1'b1, 32'h100, 32'hA5000000, F3_SW);
    while (k < 12 && cyc < 40) begin
      step();
      epat[cyc % 32] = obs_ext_gnt;
      cpat[cyc % 32] = obs_core_gnt;
      if (obs_ext_gnt)  k++;
      if (obs_core_gnt) core_done = 1;
      cyc++;
      if (k < 12) ext_set(1'b1, 1'b1, 32'h100 + 32'(4 * k), 32'hA5000000 + 32'(k), F3_SW);
      else        ext_idle();
      if (!core_done) core_set(1'b0, 32'h0, 32'h0, F3_LW);
      else            core_idle();
    end
    check_val("t4_cycles",   32'(cyc), 32'd13);
    check_val("t4_ext_gnts", epat, 32'h00001EFF);
    check_val("t4_core_gnt", cpat, 32'h00000100);
    nbad = 0;
    for (int i = 0; i < 12; i++) if (ram[64 + i] !== 32'hA5000000 + 32'(i)) nbad++;
    check_val("t4_ram_words_bad", 32'(nbad), 32'h0);
    core_idle(); ext_idle(); step();

    // 5: ext read returns registered data for exactly one cycle
    ext_set(1'b0, 1'b1, 32'h80, 32'h12345678, F3_SW); step();
    ext_set(1'b0, 1'b0, 32'h80, 32'h0, F3_LW); step();
    check_val("t5_gnt",    32'(obs_ext_gnt), 32'h1);
    check_val("t5_rvalid", 32'(obs_rvalid),  32'h1);
    check_val("t5_rdata",  obs_rdata,        32'h12345678);
    ext_idle(); step();
    check_val("t5_rvalid_drop", 32'(obs_rvalid), 32'h0);

    // 6: reset mid-burst, then a write granted in the reset cycle
    for (int i = 0; i < 3; i++) begin
      ext_set(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0, F3_LW); step();
    end
    ext_set(1'b1, 1'b0, 32'h10C, 32'h0, F3_LW);
    core_set(1'b0, 32'h40, 32'h0, F3_LW);
    rst = 1'b1; step();
    check_val("t6_rvalid_after_rst", 32'(obs_rvalid), 32'h0);
    rst = 1'b0; step();
    check_val("t6_core_gnt", 32'(obs_core_gnt), 32'h1);
    check_val("t6_ext_gnt",  32'(obs_ext_gnt),  32'h0);
    ext_idle();
    core_set(1'b1, 32'h3C, 32'hC0FFEE00, F3_SW);
    rst = 1'b1; step();
    rst = 1'b0; core_idle(); step();
    check_val("t6_rst_write", ram[15], 32'hC0FFEE00);

    // Random traffic: requesters hold until granted, then pick a new transaction.
    for (int c = 0; c < 2500; c++) begin
      if (!core_req || obs_core_gnt) begin
        if ($urandom_range(0, 9) < 6)
          core_set(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom, 3'($urandom_range(0, 7)));
        else
          core_idle();
      end
      if (!ext_req || obs_ext_gnt) begin
        if ($urandom_range(0, 9) < 7)
          ext_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
                  $urandom, 3'($urandom_range(0, 7)));
        else
          ext_idle();
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; core_idle(); ext_idle(); step();

    nbad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== shadow[i]) nbad++;
    check_val("final_ram_words_bad", 32'(nbad), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
